input_buffer_sched: RTL

Ping-pong scheduler for the input buffer of the inference datapath. It splits the buffer address space into two banks. It accepts frames of activation words from the loader stream and writes them into the free bank. It then sequences read passes for the compute engine over the full bank. The loader and the compute engine never touch the same bank at the same time, so loading frame N+1 overlaps computing on frame N.

---
 rtl/ibuf_pkg.sv | 32 +++
 rtl/ibuf_bank_tracker.sv | 73 +++++++
 rtl/input_buffer_sched.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ibuf_pkg.sv
// ibuf_pkg: shared types and helpers for the input buffer ping-pong scheduler.
//   bank_state_t : lifecycle of one buffer bank (EMPTY -> FILLING -> FULL -> DRAINING)
//   rd_state_t   : read-side sequencer states
//   bank_addr()  : packs {bank, index} into a buffer address of a given width
package ibuf_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_t;

    // Bank select lands on bit addr_w-1; index bits above the bank field are masked off.
    // Callers size-cast the 32-bit result down to their address width.
    function automatic logic [31:0] bank_addr(input logic        bank,
                                              input logic [31:0] index,
                                              input int unsigned addr_w);
        logic [31:0] idx_mask;
        idx_mask = (32'd1 << (addr_w - 32'd1)) - 32'd1;
        return ({31'd0, bank} << (addr_w - 32'd1)) | (index & idx_mask);
    endfunction

endpackage

// File: rtl/ibuf_bank_tracker.sv
// ibuf_bank_tracker: two-entry bank state array plus the write (wb) and read (rb) bank pointers.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         synchronous clear back to the reset state
//   set_filling   first beat of a frame accepted into bank[wb]
//   set_full      last beat of a frame accepted: bank[wb] FULL, wb toggles
//   set_draining  read pass started on bank[rb]
//   set_empty     last read issued: bank[rb] EMPTY, rb toggles
//   wb, rb        current pointers
//   wb_state      state of bank[wb]
//   rb_state      state of bank[rb]
module ibuf_bank_tracker
    import ibuf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        set_filling,
    input  logic        set_full,
    input  logic        set_draining,
    input  logic        set_empty,
    output logic        wb,
    output logic        rb,
    output bank_state_t wb_state,
    output bank_state_t rb_state
);

    bank_state_t bank_r [0:1];
    logic        wb_r;
    logic        rb_r;

    // Bank state and pointer update. The write side only ever touches bank[wb] while it is
    // EMPTY/FILLING and the read side only bank[rb] while FULL/DRAINING, so the two updates
    // never target the same entry and both take effect in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_r[0] <= EMPTY;
            bank_r[1] <= EMPTY;
            wb_r      <= 1'b0;
            rb_r      <= 1'b0;
        end else if (flush) begin
            bank_r[0] <= EMPTY;
            bank_r[1] <= EMPTY;
            wb_r      <= 1'b0;
            rb_r      <= 1'b0;
        end else begin
            // A one-word frame is both first and last beat: FULL takes priority.
            if (set_full) begin
                bank_r[wb_r] <= FULL;
                wb_r         <= ~wb_r;
            end else if (set_filling) begin
                bank_r[wb_r] <= FILLING;
            end else begin
                wb_r <= wb_r;
            end

            if (set_empty) begin
                bank_r[rb_r] <= EMPTY;
                rb_r         <= ~rb_r;
            end else if (set_draining) begin
                bank_r[rb_r] <= DRAINING;
            end else begin
                rb_r <= rb_r;
            end
        end
    end

    assign wb       = wb_r;
    assign rb       = rb_r;
    assign wb_state = bank_r[wb_r];
    assign rb_state = bank_r[rb_r];

endmodule

// File: rtl/input_buffer_sched.sv
// input_buffer_sched: ping-pong scheduler for the inference input buffer.
// The loader stream fills one bank while the compute engine drains the other.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   flush                       synchronous abandon of all frames
//   s_valid/s_ready/s_data      loader word stream
//   buf_wr_en/addr/data         registered buffer write port ({bank, index})
//   frame_avail                 a FULL bank is waiting and the read side is idle
//   frame_start                 compute requests a read pass (honoured only with frame_avail)
//   buf_rd_en/addr              buffer read issue ({bank, index})
//   m_valid/m_last              buffer read data valid (1 cycle after issue) / last word
//   rd_busy                     read pass in progress
module input_buffer_sched
    import ibuf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FRAME_LEN  = 2 ** (ADDR_WIDTH - 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  buf_wr_en,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr,
    output logic [DATA_WIDTH-1:0] buf_wr_data,
    output logic                  frame_avail,
    input  logic                  frame_start,
    output logic                  buf_rd_en,
    output logic [ADDR_WIDTH-1:0] buf_rd_addr,
    output logic                  m_valid,
    output logic                  m_last,
    output logic                  rd_busy
);

    localparam int IDX_W = ADDR_WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic                  wb_s;
    logic                  rb_s;
    bank_state_t           wb_state_s;
    bank_state_t           rb_state_s;

    logic [IDX_W-1:0]      wcnt_r;
    logic [IDX_W-1:0]      rcnt_r;
    rd_state_t             rd_state_r;
    rd_state_t             rd_state_nxt_s;

    logic                  s_ready_s;
    logic                  accept_s;
    logic                  last_wr_s;
    logic                  frame_avail_s;
    logic                  start_s;
    logic                  draining_s;
    logic                  last_rd_s;

    logic                  buf_wr_en_r;
    logic [ADDR_WIDTH-1:0] buf_wr_addr_r;
    logic [DATA_WIDTH-1:0] buf_wr_data_r;
    logic                  m_valid_r;
    logic                  m_last_r;
    logic [ADDR_WIDTH-1:0] buf_rd_addr_s;

    ibuf_bank_tracker u_tracker (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .set_filling  (accept_s),
        .set_full     (last_wr_s),
        .set_draining (start_s),
        .set_empty    (last_rd_s),
        .wb           (wb_s),
        .rb           (rb_s),
        .wb_state     (wb_state_s),
        .rb_state     (rb_state_s)
    );

    // Handshake and bank-transition strobes derived from registered state.
    always_comb begin
        s_ready_s     = 1'b0;
        accept_s      = 1'b0;
        last_wr_s     = 1'b0;
        frame_avail_s = 1'b0;
        start_s       = 1'b0;
        draining_s    = 1'b0;
        last_rd_s     = 1'b0;

        s_ready_s     = ((wb_state_s == EMPTY) || (wb_state_s == FILLING)) && !flush;
        accept_s      = s_valid && s_ready_s;
        last_wr_s     = accept_s && (wcnt_r == LAST_IDX);
        frame_avail_s = (rd_state_r == R_IDLE) && (rb_state_s == FULL);
        // flush wins over a same-cycle start so nothing survives the clear.
        start_s       = frame_start && frame_avail_s && !flush;
        draining_s    = (rd_state_r == R_DRAIN);
        last_rd_s     = draining_s && (rcnt_r == LAST_IDX) && !flush;
    end

    // Read FSM next-state.
    always_comb begin
        rd_state_nxt_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (start_s) begin
                    rd_state_nxt_s = R_DRAIN;
                end else begin
                    rd_state_nxt_s = R_IDLE;
                end
            end
            R_DRAIN: begin
                if (last_rd_s) begin
                    rd_state_nxt_s = R_IDLE;
                end else begin
                    rd_state_nxt_s = R_DRAIN;
                end
            end
            default: begin
                rd_state_nxt_s = R_IDLE;
            end
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_r <= R_IDLE;
        end else if (flush) begin
            rd_state_r <= R_IDLE;
        end else begin
            rd_state_r <= rd_state_nxt_s;
        end
    end

    // Write index: wraps at FRAME_LEN-1, not at the power-of-two boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_r <= '0;
        end else if (flush) begin
            wcnt_r <= '0;
        end else if (last_wr_s) begin
            wcnt_r <= '0;
        end else if (accept_s) begin
            wcnt_r <= wcnt_r + IDX_ONE;
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    // Read index: advances every drain cycle and sits at 0 while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_r <= '0;
        end else if (flush) begin
            rcnt_r <= '0;
        end else if (draining_s && !last_rd_s) begin
            rcnt_r <= rcnt_r + IDX_ONE;
        end else begin
            rcnt_r <= '0;
        end
    end

    // Registered buffer write port; address/data read as 0 when no write is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_wr_en_r   <= 1'b0;
            buf_wr_addr_r <= '0;
            buf_wr_data_r <= '0;
        end else if (flush) begin
            buf_wr_en_r   <= 1'b0;
            buf_wr_addr_r <= '0;
            buf_wr_data_r <= '0;
        end else if (accept_s) begin
            buf_wr_en_r   <= 1'b1;
            buf_wr_addr_r <= ADDR_WIDTH'(bank_addr(wb_s, 32'(wcnt_r), ADDR_WIDTH));
            buf_wr_data_r <= s_data;
        end else begin
            buf_wr_en_r   <= 1'b0;
            buf_wr_addr_r <= '0;
            buf_wr_data_r <= '0;
        end
    end

    // Read-data qualifiers trail the issue by the buffer's one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else if (flush) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else begin
            m_valid_r <= draining_s;
            m_last_r  <= last_rd_s;
        end
    end

    // Read address decoded from the state/counter registers; held at 0 while idle.
    always_comb begin
        buf_rd_addr_s = '0;
        if (draining_s) begin
            buf_rd_addr_s = ADDR_WIDTH'(bank_addr(rb_s, 32'(rcnt_r), ADDR_WIDTH));
        end else begin
            buf_rd_addr_s = '0;
        end
    end

    assign s_ready     = s_ready_s;
    assign buf_wr_en   = buf_wr_en_r;
    assign buf_wr_addr = buf_wr_addr_r;
    assign buf_wr_data = buf_wr_data_r;
    assign frame_avail = frame_avail_s;
    assign buf_rd_en   = draining_s;
    assign buf_rd_addr = buf_rd_addr_s;
    assign m_valid     = m_valid_r;
    assign m_last      = m_last_r;
    assign rd_busy     = draining_s;

endmodule
